// File: rtl/attention_head_scheduler.sv
// Time-multiplexes one attention core over NUM_HEADS heads, sums the head results
// with a wrapping adder, then runs the MLP for a fixed window and reports its result.
module attention_head_scheduler #(
   parameter int DATA_W       = 16,
   parameter int NUM_HEADS    = 2,
   parameter int CORE_TIMEOUT = 255,
   parameter int MLP_CYCLES   = 2,
   localparam int HW          = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          start,
   input  logic                          abort,
   input  logic [NUM_HEADS*DATA_W-1:0]   bias_in,
   input  logic                          core_end,
   input  logic [DATA_W-1:0]             core_out,
   input  logic [DATA_W-1:0]             mlp_out,
   output logic                          core_en,
   output logic [DATA_W-1:0]             core_bias,
   output logic                          mlp_en,
   output logic [DATA_W-1:0]             mlp_in,
   output logic [HW-1:0]                 head_idx,
   output logic                          busy,
   output logic                          done,
   output logic                          err,
   output logic [DATA_W-1:0]             o_result
);

   localparam int CNT_MAX = (CORE_TIMEOUT > MLP_CYCLES) ? CORE_TIMEOUT : MLP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(CORE_TIMEOUT);
   localparam logic [CNT_W-1:0] MLP_LAST  = CNT_W'(MLP_CYCLES - 1);
   localparam logic [HW-1:0]    LAST_HEAD = HW'(NUM_HEADS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_GAP,
      S_MLP,
      S_DONE,
      S_ERR
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   acc_q, acc_d;
   logic [DATA_W-1:0]   bias_q [NUM_HEADS];
   logic [DATA_W-1:0]   bias_d [NUM_HEADS];
   logic [DATA_W-1:0]   bias_in_a [NUM_HEADS];
   logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
   logic [HW-1:0]       head_q, head_d;
   logic                core_en_q, core_en_d;
   logic [DATA_W-1:0]   core_bias_q, core_bias_d;
   logic                mlp_en_q, mlp_en_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   result_q, result_d;

   for (genvar gi = 0; gi < NUM_HEADS; gi++) begin : g_bias_slice
      assign bias_in_a[gi] = bias_in[gi*DATA_W +: DATA_W];
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      head_d   = head_q;
      result_d = result_q;
      cnt_inc  = cnt_q + 1'b1;
      for (int h = 0; h < NUM_HEADS; h++) begin
         bias_d[h] = bias_q[h];
      end

      // Abort overrides everything, including a simultaneous start or MLP capture.
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  for (int h = 0; h < NUM_HEADS; h++) begin
                     bias_d[h] = bias_in_a[h];
                  end
                  acc_d   = '0;
                  head_d  = '0;
                  cnt_d   = '0;
                  state_d = S_RUN;
               end
            end
            S_RUN: begin
               cnt_d = cnt_inc;
               if (core_end) begin
                  acc_d = acc_q + core_out;
                  if (head_q != LAST_HEAD) begin
                     state_d = S_GAP;
                  end else begin
                     cnt_d   = '0;
                     state_d = S_MLP;
                  end
               end else if (cnt_inc == TIMEOUT_C) begin
                  state_d = S_ERR;
               end
            end
            S_GAP: begin
               head_d  = head_q + 1'b1;
               cnt_d   = '0;
               state_d = S_RUN;
            end
            S_MLP: begin
               cnt_d = cnt_inc;
               if (cnt_q == MLP_LAST) begin
                  result_d = mlp_out;
                  state_d  = S_DONE;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            S_ERR: begin
               state_d = S_ERR;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      // Outputs are decoded from the next state so they appear registered with it.
      core_en_d   = (state_d == S_RUN);
      mlp_en_d    = (state_d == S_MLP);
      busy_d      = (state_d != S_IDLE) && (state_d != S_ERR);
      done_d      = (state_d == S_DONE);
      err_d       = (state_d == S_ERR);
      core_bias_d = bias_d[head_d];
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         head_q      <= '0;
         core_en_q   <= 1'b0;
         core_bias_q <= '0;
         mlp_en_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         result_q    <= '0;
         for (int h = 0; h < NUM_HEADS; h++) begin
            bias_q[h] <= '0;
         end
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         head_q      <= head_d;
         core_en_q   <= core_en_d;
         core_bias_q <= core_bias_d;
         mlp_en_q    <= mlp_en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         result_q    <= result_d;
         for (int h = 0; h < NUM_HEADS; h++) begin
            bias_q[h] <= bias_d[h];
         end
      end
   end

   assign core_en   = core_en_q;
   assign core_bias = core_bias_q;
   assign mlp_en    = mlp_en_q;
   assign mlp_in    = acc_q;
   assign head_idx  = head_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign o_result  = result_q;

endmodule

// File: tb/tb_attention_head_scheduler.sv
// Directed bench for attention_head_scheduler: a reactive core model, per-cycle
// protocol checks, and a scoreboard that matches every done pulse to a queued pass.
module tb_attention_head_scheduler;

   localparam int DW = 16;
   localparam int NH = 2;
   localparam int TO = 8;
   localparam int MC = 2;

   logic               clk = 1'b0;
   logic               rstn = 1'b0;
   logic               start = 1'b0;
   logic               abort = 1'b0;
   logic [NH*DW-1:0]   bias_in = '0;
   logic               core_end = 1'b0;
   logic [DW-1:0]      core_out = '0;
   logic [DW-1:0]      mlp_out = '0;
   logic               core_en;
   logic [DW-1:0]      core_bias;
   logic               mlp_en;
   logic [DW-1:0]      mlp_in;
   logic [0:0]         head_idx;
   logic               busy;
   logic               done;
   logic               err;
   logic [DW-1:0]      o_result;

   attention_head_scheduler #(
      .DATA_W(DW), .NUM_HEADS(NH), .CORE_TIMEOUT(TO), .MLP_CYCLES(MC)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort), .bias_in(bias_in),
      .core_end(core_end), .core_out(core_out), .mlp_out(mlp_out),
      .core_en(core_en), .core_bias(core_bias), .mlp_en(mlp_en), .mlp_in(mlp_in),
      .head_idx(head_idx), .busy(busy), .done(done), .err(err), .o_result(o_result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [DW-1:0] res;
      logic [DW-1:0] acc;
      int            cyc;
   } exp_t;
   exp_t sb[$];

   logic [DW-1:0] head_vals [NH];
   int            core_lat = 0;
   bit            poke_end = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
      end
   endtask

   // Core model: raises core_end in the core_lat-th enabled cycle (never if 0).
   // While disabled it drives core_end from poke_end to exercise stray pulses.
   initial begin
      int en_cnt;
      en_cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (core_en === 1'b1) begin
            en_cnt++;
            core_end = (core_lat != 0) && (en_cnt == core_lat);
            core_out = head_vals[head_idx];
         end else begin
            en_cnt   = 0;
            core_end = poke_end;
            core_out = 16'h7777;
         end
      end
   end

   // Scoreboard monitor: every done pulse must match the oldest queued pass.
   initial begin
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            exp_t e;
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done @cyc %0d: got done=1, want no pending pass", cyc);
            end else begin
               e = sb.pop_front();
               chk("o_result", o_result, e.res);
               chk("mlp_in", mlp_in, e.acc);
               chk("done_cycle", cyc, e.cyc);
               $display("[TB] pass done cyc=%0d o_result=0x%h mlp_in=0x%h", cyc, o_result, mlp_in);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Drives start in an IDLE cycle (cycle 0 of the pass) and returns its cycle number.
   task automatic begin_pass(input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                             input logic [DW-1:0] h0, input logic [DW-1:0] h1,
                             input int lat, input logic [DW-1:0] mo, output int c0);
      @(negedge clk);
      chk("idle_before_start", busy, 0);
      bias_in      = {b1, b0};
      head_vals[0] = h0;
      head_vals[1] = h1;
      core_lat     = lat;
      mlp_out      = mo;
      start        = 1'b1;
      c0           = cyc;
   endtask

   task automatic run_pass(input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                           input logic [DW-1:0] h0, input logic [DW-1:0] h1,
                           input int lat, input logic [DW-1:0] mo, input bit disturb);
      int   c0;
      int   n;
      exp_t e;
      bit   run1, run2;
      n = 2 * lat + 1 + MC + 1;
      begin_pass(b0, b1, h0, h1, lat, mo, c0);
      e.res = mo;
      e.acc = h0 + h1;
      e.cyc = c0 + n;
      sb.push_back(e);
      $display("[TB] pass start cyc=%0d lat=%0d expect acc=0x%h result=0x%h", c0, lat, e.acc, mo);
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         start    = disturb && (k == 3);
         poke_end = disturb && (k == lat);
         if (disturb && k == 2) bias_in = ~bias_in;
         run1 = (k >= 1) && (k <= lat);
         run2 = (k >= lat + 2) && (k <= 2 * lat + 1);
         chk("core_en", core_en, run1 || run2);
         if (run1) chk("core_bias_h0", core_bias, b0);
         if (run2) chk("core_bias_h1", core_bias, b1);
         chk("head_idx", head_idx, k >= lat + 2);
         chk("mlp_en", mlp_en, (k >= 2 * lat + 2) && (k <= 2 * lat + 1 + MC));
         chk("busy", busy, 1);
      end
      start    = 1'b0;
      poke_end = 1'b0;
   endtask

   initial begin
      int c0;
      head_vals[0] = '0;
      head_vals[1] = '0;

      // Reset held three cycles with start high.
      rstn  = 1'b0;
      start = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_core_en", core_en, 0);
      chk("rst_core_bias", core_bias, 0);
      chk("rst_mlp_en", mlp_en, 0);
      chk("rst_mlp_in", mlp_in, 0);
      chk("rst_head_idx", head_idx, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_o_result", o_result, 0);
      $display("[TB] reset checked cyc=%0d", cyc);
      rstn  = 1'b1;
      start = 1'b0;

      run_pass(16'h1111, 16'h2222, 16'h0010, 16'h0020, 5, 16'h1234, 1'b0);
      // Back-to-back, wrapping sum, with stray start / core_end / bias changes.
      run_pass(16'hAAAA, 16'h5555, 16'hFFF0, 16'h0020, 3, 16'hBEEF, 1'b1);
      // core_end lands exactly on the timeout count for both heads.
      run_pass(16'h0101, 16'h0202, 16'h0003, 16'h0004, 8, 16'h00C3, 1'b0);

      // Abort during the first MLP cycle.
      begin_pass(16'h0A0A, 16'h0B0B, 16'h0001, 16'h0002, 3, 16'h5A5A, c0);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("abort_pre_mlp_en", mlp_en, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_mlp_en", mlp_en, 0);
      chk("abort_busy", busy, 0);
      chk("abort_core_en", core_en, 0);
      chk("abort_err", err, 0);
      chk("abort_o_result_kept", o_result, 16'h00C3);
      $display("[TB] abort in MLP cyc=%0d o_result=0x%h", cyc, o_result);

      // Abort and start together in IDLE: the pass must not begin.
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("abort_start_busy", busy, 0);
      chk("abort_start_core_en", core_en, 0);
      $display("[TB] abort+start in IDLE cyc=%0d busy=%0b", cyc, busy);

      // Timeout: core never finishes.
      begin_pass(16'h0C0C, 16'h0D0D, 16'h0000, 16'h0000, 0, 16'h9999, c0);
      for (int k = 1; k <= TO; k++) begin
         @(negedge clk);
         start = 1'b0;
         chk("to_core_en", core_en, 1);
         chk("to_err_low", err, 0);
      end
      @(negedge clk);
      chk("to_err", err, 1);
      chk("to_core_en_off", core_en, 0);
      chk("to_busy", busy, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("to_err_sticky", err, 1);
      chk("to_start_ignored", busy, 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("to_abort_err", err, 0);
      chk("to_abort_o_result", o_result, 16'h00C3);
      $display("[TB] timeout and abort cyc=%0d err=%0b", cyc, err);

      // Reset during MLP discards the pass and clears o_result.
      begin_pass(16'h0E0E, 16'h0F0F, 16'h0005, 16'h0006, 2, 16'h6666, c0);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("rstmlp_pre_mlp_en", mlp_en, 1);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      chk("rstmlp_mlp_en", mlp_en, 0);
      chk("rstmlp_busy", busy, 0);
      chk("rstmlp_o_result", o_result, 0);
      chk("rstmlp_mlp_in", mlp_in, 0);
      chk("rstmlp_head_idx", head_idx, 0);
      chk("rstmlp_core_bias", core_bias, 0);
      $display("[TB] reset in MLP cyc=%0d o_result=0x%h", cyc, o_result);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/attention_head_scheduler.md
# attention_head_scheduler

Sequencer that time-multiplexes a single attention core across `NUM_HEADS` heads and then drives the MLP stage, replacing the parallel two-core arrangement where area matters. It holds the per-head biases, runs the core once per head, and accumulates head outputs with a wrapping sum. It then enables the MLP for a fixed window and returns the MLP result with a one-cycle `done` pulse. It sits between the layer-level controller and one attention core plus one MLP core.

## Interface
- `DATA_W`, 16, width of activations, biases and accumulator (matches `att_width`).
- `NUM_HEADS`, 2, heads per pass (≥1).
- `CORE_TIMEOUT`, 255, maximum cycles `core_en` may stay high for one head without `core_end`.
- `MLP_CYCLES`, 2, cycles `mlp_en` is held high (≥1).

Ports:
- `clk`  in  1  clock; single clock domain, all logic on the rising edge.
- `rstn`  in  1  reset, synchronous and active-low.
- `start`  in  1  begin a pass; sampled only in IDLE.
- `abort`  in  1  return to IDLE next cycle from any state.
- `bias_in`  in  `NUM_HEADS*DATA_W`  head h bias at bits `[h*DATA_W +: DATA_W]`; latched on accepted `start`.
- `core_end`  in  1  attention core finished current head.
- `core_out`  in  `DATA_W`  attention core result; valid when `core_end`=1.
- `mlp_out`  in  `DATA_W`  MLP result.
- `core_en`  out  1  attention core enable.
- `core_bias`  out  `DATA_W`  latched bias of current head.
- `mlp_en`  out  1  MLP enable.
- `mlp_in`  out  `DATA_W`  accumulated head sum.
- `head_idx`  out  `$clog2(NUM_HEADS)` (min 1)  current head.
- `busy`  out  1  high in every state except IDLE and ERR.
- `done`  out  1  one-cycle pulse when `o_result` is valid.
- `err`  out  1  timeout flag; sticky until `abort` or reset.
- `o_result`  out  `DATA_W`  MLP result of the last completed pass.

## Operation
States: IDLE, RUN, GAP, MLP, DONE, ERR.

- **IDLE**
  - `start`=1: latch all biases, set `acc`=0, `head_idx`=0, clear the timeout counter, go to RUN.
- **RUN**
  - `core_en`=1 and `core_bias`=bias[`head_idx`].
  - The counter increments each cycle.
  - On `core_end`=1: `acc` ← `acc`+`core_out`, modulo 2^DATA_W with no saturation. Then:
    - if `head_idx`<NUM_HEADS-1: go to GAP;
    - otherwise go to MLP with a zeroed counter.
- **GAP**
  - One cycle with `core_en`=0, which re-arms the core.
  - `head_idx`++, counter cleared, go to RUN.
- **MLP**
  - `mlp_en`=1 and `mlp_in`=`acc`, held for `MLP_CYCLES` cycles.
  - On the last MLP cycle, `o_result` ← `mlp_out`. Go to DONE.
- **DONE**
  - `done`=1 for one cycle, go to IDLE.
- **ERR**
  - Entered from RUN when the counter reaches `CORE_TIMEOUT` without `core_end`.
  - Outputs: `err`=1, `core_en`=0, `mlp_en`=0, `busy`=0.
  - Left only on `abort` or reset.

Rules for inputs that arrive at other times:
- `start` outside IDLE is ignored.
- `core_end` outside RUN is ignored.
- `bias_in` changes after `start` have no effect on the running pass.
- `mlp_in` shows `acc` in all states.
- `o_result` holds its value until the next DONE.

## Timing
- **Reset** (`rstn`=0 at an edge): state IDLE, and every output is 0 (`core_en`, `core_bias`, `mlp_en`, `mlp_in`, `head_idx`, `busy`, `done`, `err`, `o_result`); `acc`, the latched biases and the counter are also 0. Reset mid-pass discards the pass.
- **Output registering:** all outputs are registered or decoded directly from state registers. None depends combinationally on inputs.
- **Pass latency**, where `start` is accepted at cycle 0 and the core asserts `core_end` in its L-th enabled cycle for every head:
  - RUN for head 0 covers cycles 1..L.
  - Each following head adds 1 GAP cycle plus L RUN cycles.
  - MLP covers the next `MLP_CYCLES` cycles.
  - `done` is high at cycle NUM_HEADS·L + (NUM_HEADS−1) + MLP_CYCLES + 1.
- **Back-to-back passes:** `start` can be accepted again in the IDLE cycle that follows DONE.
- **Timeout:**
  - If `core_end` is still 0 when the counter would reach `CORE_TIMEOUT`, `err` rises on the next edge.
  - If `core_end` and timeout coincide, `core_end` wins.
- **Abort:** `abort`=1 at an edge forces IDLE with `core_en`, `mlp_en`, `busy`, `done` and `err` all 0; `o_result` is kept. If `abort` and `start` are both high in IDLE, `abort` wins and the pass does not start.

## Test plan
1. **Reset:** hold `rstn`=0 for 3 cycles with `start`=1 → all outputs 0, state IDLE.
2. **Nominal pass:** `NUM_HEADS`=2, `MLP_CYCLES`=2, core L=5; head outputs 0x0010 and 0x0020; `mlp_out`=0x1234 → `mlp_in`=0x0030, `done` at cycle 14, `o_result`=0x1234. `core_bias` equals bias0 during cycles 1–5 and bias1 during cycles 7–11, and `core_en`=0 at cycle 6.
3. **Accumulator wrap:** head outputs 0xFFF0 and 0x0020 → `mlp_in`=0x0010.
4. **Timeout:** `CORE_TIMEOUT`=8 and `core_end` never asserted → `err`=1 after 8 RUN cycles, `core_en`=0. `abort` then clears `err` the next cycle.
5. **Ignored inputs:** `start` pulsed during RUN and `core_end` pulsed during GAP → no change to state, `acc` or `head_idx`. Changing `bias_in` mid-pass → `core_bias` is unchanged.
6. **Mid-pass interrupts:** reset and `abort` asserted during MLP → next cycle IDLE and `mlp_en`=0. After the abort, `o_result` retains the previous pass value.
